// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ requesters.
// Optional grant/carry-out statistics counters are enabled with `define ADDER_ARB_STATS_EN.
module adder_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    input  logic [WIDTH:0]             add_result,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH:0]             resp_data,
    output logic [ID_W-1:0]            resp_id,
    output logic                       busy
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]                grant_count,
    output logic [15:0]                ovf_count
`endif
);

    localparam int unsigned RES_W = WIDTH + 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic [RES_W-1:0]   resp_data_q, resp_data_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic               resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   op_a [NUM_REQ];
    logic [WIDTH-1:0]   op_b [NUM_REQ];
    logic               found_c;
    logic [ID_W-1:0]    win_c;

`ifdef ADDER_ARB_STATS_EN
    logic [CNT_W-1:0]   grant_cnt_q, grant_cnt_d;
    logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*WIDTH +: WIDTH];
        assign op_b[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: indices above last first, then wrap to 0..last.
    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found_c && (i > 32'(last_q)) && req_valid[i]) begin
                found_c = 1'b1;
                win_c   = ID_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found_c && (i <= 32'(last_q)) && req_valid[i]) begin
                found_c = 1'b1;
                win_c   = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        req_ready    = '0;
`ifdef ADDER_ARB_STATS_EN
        grant_cnt_d  = grant_cnt_q;
        ovf_cnt_d    = ovf_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    req_ready[win_c] = 1'b1;
                    add_a_d          = op_a[win_c];
                    add_b_d          = op_b[win_c];
                    resp_id_d        = win_c;
                    last_d           = win_c;
                    state_d          = CALC;
`ifdef ADDER_ARB_STATS_EN
                    if (grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + CNT_W'(1);
`endif
                end
            end
            CALC: begin
                resp_data_d  = add_result;
                resp_valid_d = 1'b1;
                state_d      = RESP;
`ifdef ADDER_ARB_STATS_EN
                if (add_result[WIDTH] && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_q       <= ID_W'(NUM_REQ - 1);
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef ADDER_ARB_STATS_EN
            grant_cnt_q  <= '0;
            ovf_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
`ifdef ADDER_ARB_STATS_EN
            grant_cnt_q  <= grant_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
`endif
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
`ifdef ADDER_ARB_STATS_EN
    assign grant_count = grant_cnt_q;
    assign ovf_count   = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table, corner sequences,
// and a randomized run checked against a transaction-level reference model.
module tb_adder_arbiter;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W:0]       add_result;
    logic             resp_valid;
    logic             resp_ready;
    logic [W:0]       resp_data;
    logic [IW-1:0]    resp_id;
    logic             busy;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]      grant_count;
    logic [15:0]      ovf_count;
`endif

    adder_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
`ifdef ADDER_ARB_STATS_EN
        ,
        .grant_count(grant_count),
        .ovf_count  (ovf_count)
`endif
    );

    // The external shared adder.
    assign add_result = {1'b0, add_a} + {1'b0, add_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } vec_t;

    typedef struct {
        logic [W:0]   sum;
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           t;
    } txn_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    function automatic logic [N-1:0] onehot(input int id);
        logic [N-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        tick();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_single(input vec_t v);
        tick();
        set_req(v.id, v.a, v.b);
        req_valid  = onehot(v.id);
        resp_ready = 1'b1;
        #1;
        chk("single_ready", 64'(req_ready), 64'(onehot(v.id)));
        tick();
        req_valid = '0;
        #1;
        chk("single_calc_busy", 64'(busy), 64'd1);
        chk("single_calc_rv", 64'(resp_valid), 64'd0);
        chk("single_add_a", 64'(add_a), 64'(v.a));
        chk("single_add_b", 64'(add_b), 64'(v.b));
        tick();
        chk("single_rv", 64'(resp_valid), 64'd1);
        chk("single_data", 64'(resp_data), 64'(v.exp));
        chk("single_id", 64'(resp_id), 64'(v.id));
        tick();
        chk("single_done_rv", 64'(resp_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   order[5];
        logic [W-1:0] rr_a[N];
        logic [W-1:0] rr_b[N];
        int   n_ovf_vec;
        // random-model state
        logic         pend[N];
        logic [W-1:0] ma[N];
        logic [W-1:0] mb[N];
        int           last_m;
        int           m_grant;
        int           m_ovf;
        txn_t         q[$];

        vecs[0] = '{id: 0, a: 32'h0000_4234, b: 32'h0000_5678, exp: 33'h0_0000_98AC};
        vecs[1] = '{id: 2, a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp: 33'h1_0000_0000};
        vecs[2] = '{id: 1, a: 32'h0000_0000, b: 32'h0000_0000, exp: 33'h0_0000_0000};
        vecs[3] = '{id: 3, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, exp: 33'h1_FFFF_FFFE};
        vecs[4] = '{id: 1, a: 32'h8000_0000, b: 32'h8000_0000, exp: 33'h1_0000_0000};
        order   = '{0, 1, 2, 3, 0};

        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        chk("rst_add_a", 64'(add_a), 64'd0);
        chk("rst_add_b", 64'(add_b), 64'd0);
        chk("rst_data", 64'(resp_data), 64'd0);
        chk("rst_id", 64'(resp_id), 64'd0);
        chk("rst_rv", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
`ifdef ADDER_ARB_STATS_EN
        chk("rst_grant_cnt", 64'(grant_count), 64'd0);
        chk("rst_ovf_cnt", 64'(ovf_count), 64'd0);
`endif
        tick();
        rst = 1'b0;

        // Directed vector table, then idle window with counters frozen.
        n_ovf_vec = 0;
        for (int k = 0; k < 5; k++) begin
            run_single(vecs[k]);
            if (vecs[k].exp[W]) n_ovf_vec++;
        end
        resp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_ready", 64'(req_ready), 64'd0);
            chk("idle_rv", 64'(resp_valid), 64'd0);
`ifdef ADDER_ARB_STATS_EN
            chk("idle_grant_cnt", 64'(grant_count), 64'd5);
            chk("idle_ovf_cnt", 64'(ovf_count), 64'(n_ovf_vec));
`endif
        end

        // Round-robin with all requesters continuously active.
        do_reset();
        for (int i = 0; i < N; i++) begin
            rr_a[i] = 32'h1000_0000 * (i + 1) + 32'(i);
            rr_b[i] = 32'h0300_0000 + 32'(i * 7);
        end
        rr_a[3] = 32'hFFFF_FFF0;
        rr_b[3] = 32'h0000_0020;
        tick();
        for (int i = 0; i < N; i++) set_req(i, rr_a[i], rr_b[i]);
        req_valid  = '1;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", 64'(req_ready), 64'(onehot(order[k])));
            tick();
            chk("rr_calc_ready", 64'(req_ready), 64'd0);
            chk("rr_calc_rv", 64'(resp_valid), 64'd0);
            tick();
            chk("rr_rv", 64'(resp_valid), 64'd1);
            chk("rr_id", 64'(resp_id), 64'(order[k]));
            chk("rr_data", 64'(resp_data),
                64'({1'b0, rr_a[order[k]]} + {1'b0, rr_b[order[k]]}));
            chk("rr_resp_ready", 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = '0;

        // Backpressure: response held while consumer stalls; others wait.
        do_reset();
        tick();
        set_req(1, 32'h1234_5678, 32'h1111_1111);
        set_req(0, 32'h5, 32'h6);
        set_req(2, 32'h7, 32'h8);
        set_req(3, 32'h9, 32'hA);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        #1;
        chk("bp_grant", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1101;
        #1;
        chk("bp_calc_ready", 64'(req_ready), 64'd0);
        tick();
        chk("bp_rv", 64'(resp_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_rv", 64'(resp_valid), 64'd1);
            chk("bp_hold_data", 64'(resp_data), 64'h0_2345_6789);
            chk("bp_hold_id", 64'(resp_id), 64'd1);
            chk("bp_hold_ready", 64'(req_ready), 64'd0);
            chk("bp_hold_busy", 64'(busy), 64'd1);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_rel_rv", 64'(resp_valid), 64'd0);
        chk("bp_rel_busy", 64'(busy), 64'd0);
        chk("bp_rel_next_grant", 64'(req_ready), 64'b0100);
        req_valid = '0;

        // Reset asserted during CALC discards the transaction.
        do_reset();
        tick();
        set_req(2, 32'hFFFF_FFFF, 32'h0000_0001);
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        #1;
        chk("mr_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("mr_calc_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("mr_add_a", 64'(add_a), 64'd0);
        chk("mr_add_b", 64'(add_b), 64'd0);
        chk("mr_rv", 64'(resp_valid), 64'd0);
        chk("mr_data", 64'(resp_data), 64'd0);
        chk("mr_id", 64'(resp_id), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
`ifdef ADDER_ARB_STATS_EN
        chk("mr_grant_cnt", 64'(grant_count), 64'd0);
        chk("mr_ovf_cnt", 64'(ovf_count), 64'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'(200 + i));
        req_valid = '1;
        #1;
        chk("mr_after_grant", 64'(req_ready), 64'b0001);
        chk("mr_after_rv", 64'(resp_valid), 64'd0);
        tick();
        req_valid = '0;
        chk("mr_after_add_a", 64'(add_a), 64'd100);
        tick();
        tick();
        chk("mr_after_data", 64'(resp_data), 64'd300);
        chk("mr_after_id", 64'(resp_id), 64'd0);

        // Randomized run against a transaction-level model.
        do_reset();
        last_m  = N - 1;
        m_grant = 0;
        m_ovf   = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            ma[i]   = '0;
            mb[i]   = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            logic         idle;
            logic         exp_rv;
            logic [N-1:0] exp_rdy;
            int           w;
            int           j;
            tick();
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 24) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    ma[i]   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
                    mb[i]   = $urandom;
                end
                req_valid[i] = pend[i];
                set_req(i, ma[i], mb[i]);
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            #1;
            idle   = (q.size() == 0);
            exp_rv = 1'b0;
            if (!idle) exp_rv = ((c - q[0].t) >= 2);
            chk("rnd_busy", 64'(busy), 64'(!idle));
            chk("rnd_rv", 64'(resp_valid), 64'(exp_rv));
            if (!idle) begin
                chk("rnd_add_a", 64'(add_a), 64'(q[0].a));
                chk("rnd_add_b", 64'(add_b), 64'(q[0].b));
            end
            if (exp_rv) begin
                chk("rnd_data", 64'(resp_data), 64'(q[0].sum));
                chk("rnd_id", 64'(resp_id), 64'(q[0].id));
            end
`ifdef ADDER_ARB_STATS_EN
            chk("rnd_grant_cnt", 64'(grant_count), 64'(m_grant));
            chk("rnd_ovf_cnt", 64'(ovf_count), 64'(m_ovf));
`endif
            w       = -1;
            exp_rdy = '0;
            if (idle) begin
                for (int k = 1; k <= N; k++) begin
                    j = (last_m + k) % N;
                    if (w < 0 && pend[j]) w = j;
                end
            end
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));

            if (!idle && (c - q[0].t) == 1 && q[0].sum[W] && m_ovf < 16'hFFFF) m_ovf++;
            if (exp_rv && resp_ready) void'(q.pop_front());
            if (w >= 0) begin
                q.push_back('{sum: {1'b0, ma[w]} + {1'b0, mb[w]}, id: w, a: ma[w], b: mb[w], t: c});
                last_m  = w;
                pend[w] = 1'b0;
                if (m_grant < 16'hFFFF) m_grant++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
